// File: rtl/mbus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mbus_ctrl_pkg
//  Description : Shared definitions for the gen2 MBus master control node.
//                Holds the FSM state encoding, the RESET_CAUSE and
//                interrupt-pending codes, and a width helper for sizing
//                the down-counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package mbus_ctrl_pkg;

    localparam int unsigned c_STATE_W = 4;
    typedef logic [c_STATE_W-1:0] state_t;

    // Bus controller states; the comment gives the CLK_OUT level
    localparam state_t c_ST_IDLE      = 4'd0;   // 1
    localparam state_t c_ST_START_POS = 4'd1;   // 1
    localparam state_t c_ST_START_NEG = 4'd2;   // 0
    localparam state_t c_ST_ARB_POS   = 4'd3;   // 1
    localparam state_t c_ST_ARB_NEG   = 4'd4;   // 0
    localparam state_t c_ST_DRV1_POS  = 4'd5;   // 1
    localparam state_t c_ST_DRV1_NEG  = 4'd6;   // 0
    localparam state_t c_ST_LAT1_POS  = 4'd7;   // 1
    localparam state_t c_ST_LAT1_NEG  = 4'd8;   // 0
    localparam state_t c_ST_DRV2_POS  = 4'd9;   // 1
    localparam state_t c_ST_DRV2_NEG  = 4'd10;  // 0
    localparam state_t c_ST_LAT2_POS  = 4'd11;  // 1
    localparam state_t c_ST_LAT2_NEG  = 4'd12;  // 0
    localparam state_t c_ST_RST_POS   = 4'd13;  // 1
    localparam state_t c_ST_RST_NEG   = 4'd14;  // 0
    localparam state_t c_ST_DISABLE   = 4'd15;  // 1

    // RESET_CAUSE codes
    localparam logic [1:0] c_CAUSE_NONE = 2'b00;
    localparam logic [1:0] c_CAUSE_IRQ  = 2'b01;
    localparam logic [1:0] c_CAUSE_WDOG = 2'b10;

    // Interrupt request pipeline: armed in LAT2_POS, promoted one bit-pair later
    localparam logic [1:0] c_PEND_NONE  = 2'b00;
    localparam logic [1:0] c_PEND_ARMED = 2'b01;
    localparam logic [1:0] c_PEND_FIRE  = 2'b10;

    // Number of bits needed to hold any value in 0..max_val (minimum 1)
    function automatic int unsigned f_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mbus_din_filter.sv
`default_nettype none
// ============================================================================
//  Module      : mbus_din_filter
//  Description : Start-request glitch filter. Shifts in lane-0 samples and
//                flags a start once FILT_DEPTH consecutive samples are low.
//                While i_clr is high the history is forced to all ones so a
//                stale low run can never leak into the next idle period.
//  Ports       : CLK_IN   - system clock
//                RESET    - asynchronous active-low reset
//                i_clr    - force history to all ones
//                i_sample - lane-0 data sample
//                o_start  - start request detected
//  Revision    : 1.0 - initial release
// ============================================================================
module mbus_din_filter #(
    parameter int unsigned FILT_DEPTH = 4
) (
    input  logic CLK_IN,
    input  logic RESET,
    input  logic i_clr,
    input  logic i_sample,
    output logic o_start
);
    import mbus_ctrl_pkg::*;

    logic [FILT_DEPTH-1:0] r_shift;

    generate
        if (FILT_DEPTH == 1) begin : g_depth_one
            always_ff @(posedge CLK_IN or negedge RESET) begin
                if (!RESET) begin
                    r_shift <= '1;
                end else if (i_clr) begin
                    r_shift <= '1;
                end else begin
                    r_shift <= i_sample;
                end
            end
        end else begin : g_depth_many
            always_ff @(posedge CLK_IN or negedge RESET) begin
                if (!RESET) begin
                    r_shift <= '1;
                end else if (i_clr) begin
                    r_shift <= '1;
                end else begin
                    r_shift <= {r_shift[FILT_DEPTH-2:0], i_sample};
                end
            end
        end
    endgenerate

    assign o_start = (r_shift == '0);

endmodule
`default_nettype wire

// File: rtl/mbus_ctrl_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : mbus_ctrl_gen2
//  Description : Second-generation MBus master control node. Generates the
//                bus clock and the start / arbitration / data-forwarding /
//                bus-reset sequences for LANES data lanes, with a runtime
//                clock divider, a start glitch filter, interrupt detection
//                on lane 0 and a bit-pair watchdog that forces a bus reset.
//  Ports       : CLK_IN      - system clock
//                RESET       - asynchronous active-low reset
//                CLK_DIV     - CLK_OUT half-period minus 1 (CLK_IN cycles)
//                DIN         - ring return data
//                DOUT        - forwarded data (all ones while held)
//                CLK_OUT     - bus clock
//                BUS_BUSY    - controller not idle
//                RESET_CAUSE - 01 interrupt reset, 10 watchdog reset
//                RESET_DONE  - one-cycle pulse on return to idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mbus_ctrl_gen2 #(
    parameter int unsigned LANES               = 1,
    parameter int unsigned DIV_W               = 8,
    parameter int unsigned FILT_DEPTH          = 4,
    parameter int unsigned START_HALF_CYCLES   = 6,
    parameter int unsigned RESET_CYCLES        = 4,
    parameter int unsigned DISABLE_HALF_CYCLES = 6,
    parameter int unsigned MAX_BITS            = 1024
) (
    input  logic             CLK_IN,
    input  logic             RESET,
    input  logic [DIV_W-1:0] CLK_DIV,
    input  logic [LANES-1:0] DIN,
    output logic [LANES-1:0] DOUT,
    output logic             CLK_OUT,
    output logic             BUS_BUSY,
    output logic [1:0]       RESET_CAUSE,
    output logic             RESET_DONE
);
    import mbus_ctrl_pkg::*;

    // One shared down-counter sequences START_POS halves, reset cycles and
    // DISABLE halves, so it is sized for the largest of the three.
    localparam int unsigned c_SEQ_TOP =
        (START_HALF_CYCLES > RESET_CYCLES)
            ? ((START_HALF_CYCLES > DISABLE_HALF_CYCLES) ? START_HALF_CYCLES : DISABLE_HALF_CYCLES)
            : ((RESET_CYCLES > DISABLE_HALF_CYCLES) ? RESET_CYCLES : DISABLE_HALF_CYCLES);
    localparam int unsigned c_SEQ_W  = f_width(c_SEQ_TOP - 1);
    localparam int unsigned c_BCNT_W = f_width((MAX_BITS == 0) ? 1 : MAX_BITS - 1);

    localparam logic [c_SEQ_W-1:0]  c_START_LAST = c_SEQ_W'(START_HALF_CYCLES - 1);
    localparam logic [c_SEQ_W-1:0]  c_RST_LAST   = c_SEQ_W'(RESET_CYCLES - 1);
    localparam logic [c_SEQ_W-1:0]  c_DIS_LAST   = c_SEQ_W'(DISABLE_HALF_CYCLES - 1);
    localparam logic [c_BCNT_W-1:0] c_BITS_LAST  = c_BCNT_W'((MAX_BITS == 0) ? 0 : MAX_BITS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_div_q;
    logic [DIV_W-1:0]    r_cnt;
    logic [c_SEQ_W-1:0]  r_seq;
    logic [c_BCNT_W-1:0] r_bcnt;
    logic [LANES-1:0]    r_din;
    logic [1:0]          r_hist;
    logic [1:0]          r_pend;
    logic [1:0]          r_cause;
    logic                r_hold;
    logic                r_done;

    logic w_start;
    logic w_half_end;
    logic w_wdog;
    logic w_bus_reset;

    // ------------------------------------------------------------------------
    // Start detector on lane 0, only active while idle
    // ------------------------------------------------------------------------
    mbus_din_filter #(
        .FILT_DEPTH (FILT_DEPTH)
    ) u_din_filter (
        .CLK_IN   (CLK_IN),
        .RESET    (RESET),
        .i_clr    (r_state != c_ST_IDLE),
        .i_sample (DIN[0]),
        .o_start  (w_start)
    );

    assign w_half_end  = (r_cnt == '0);
    assign w_wdog      = (MAX_BITS != 0) && (r_bcnt == c_BITS_LAST);
    // Watchdog and a promoted interrupt both lead to the same single reset
    assign w_bus_reset = w_wdog || (r_pend == c_PEND_FIRE);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK_IN or negedge RESET) begin
        if (!RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. Apart from leaving IDLE, every transition
    // happens on the last cycle of a half-period.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:      if (w_start) w_state_nxt = c_ST_START_POS;
            c_ST_START_POS: if (w_half_end && (r_seq == '0)) w_state_nxt = c_ST_START_NEG;
            c_ST_START_NEG: if (w_half_end) w_state_nxt = c_ST_ARB_POS;
            c_ST_ARB_POS:   if (w_half_end) w_state_nxt = c_ST_ARB_NEG;
            c_ST_ARB_NEG:   if (w_half_end) w_state_nxt = c_ST_DRV1_POS;
            c_ST_DRV1_POS:  if (w_half_end) w_state_nxt = c_ST_DRV1_NEG;
            c_ST_DRV1_NEG:  if (w_half_end) w_state_nxt = c_ST_LAT1_POS;
            c_ST_LAT1_POS:  if (w_half_end) w_state_nxt = c_ST_LAT1_NEG;
            c_ST_LAT1_NEG:  if (w_half_end) w_state_nxt = c_ST_DRV2_POS;
            c_ST_DRV2_POS:  if (w_half_end) w_state_nxt = c_ST_DRV2_NEG;
            c_ST_DRV2_NEG:  if (w_half_end) w_state_nxt = c_ST_LAT2_POS;
            c_ST_LAT2_POS:  if (w_half_end) w_state_nxt = c_ST_LAT2_NEG;
            c_ST_LAT2_NEG:
                if (w_half_end) begin
                    w_state_nxt = w_bus_reset ? c_ST_RST_POS : c_ST_DRV1_POS;
                end
            c_ST_RST_POS:   if (w_half_end) w_state_nxt = c_ST_RST_NEG;
            c_ST_RST_NEG:
                if (w_half_end) begin
                    w_state_nxt = (r_seq == '0) ? c_ST_DISABLE : c_ST_RST_POS;
                end
            c_ST_DISABLE:   if (w_half_end && (r_seq == '0)) w_state_nxt = c_ST_IDLE;
            default:        w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs decoded from the registered state only
    // ------------------------------------------------------------------------
    always_comb begin
        BUS_BUSY = (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_START_NEG, c_ST_ARB_NEG, c_ST_DRV1_NEG, c_ST_LAT1_NEG,
            c_ST_DRV2_NEG, c_ST_LAT2_NEG, c_ST_RST_NEG:
                CLK_OUT = 1'b0;
            default:
                CLK_OUT = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: timer, sequencing counter, hold, history, interrupt and
    // watchdog bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK_IN or negedge RESET) begin
        if (!RESET) begin
            r_din   <= '1;
            r_div_q <= '0;
            r_cnt   <= '0;
            r_seq   <= '0;
            r_bcnt  <= '0;
            r_hist  <= '0;
            r_pend  <= c_PEND_NONE;
            r_cause <= c_CAUSE_NONE;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_din  <= DIN;
            r_done <= 1'b0;

            // Half-period timer: stopped in IDLE, reloads from the divider
            // latched at IDLE exit so CLK_DIV edits mid-transaction are inert.
            if (r_state == c_ST_IDLE) begin
                r_cnt <= '0;
                if (w_start) begin
                    r_div_q <= CLK_DIV;
                    r_cnt   <= CLK_DIV;
                    r_seq   <= c_START_LAST;
                    r_cause <= c_CAUSE_NONE;
                end
            end else begin
                r_cnt <= w_half_end ? r_div_q : (r_cnt - 1'b1);
            end

            if (w_half_end) begin
                case (r_state)
                    c_ST_START_POS: begin
                        if (r_seq != '0) r_seq <= r_seq - 1'b1;
                    end
                    c_ST_ARB_NEG: begin
                        r_hold <= 1'b0;
                    end
                    c_ST_DRV1_NEG: begin
                        r_hist[0] <= r_din[0];
                    end
                    c_ST_DRV2_NEG: begin
                        r_hist[1] <= r_din[0];
                    end
                    c_ST_LAT2_NEG: begin
                        r_bcnt <= r_bcnt + 1'b1;
                        if (w_bus_reset) begin
                            r_hold  <= 1'b1;
                            r_seq   <= c_RST_LAST;
                            r_cause <= w_wdog ? c_CAUSE_WDOG : c_CAUSE_IRQ;
                        end
                    end
                    c_ST_RST_NEG: begin
                        r_seq <= (r_seq == '0) ? c_DIS_LAST : (r_seq - 1'b1);
                    end
                    c_ST_DISABLE: begin
                        if (r_seq == '0) begin
                            r_done <= 1'b1;
                            r_cnt  <= '0;
                            r_bcnt <= '0;
                            r_pend <= c_PEND_NONE;
                            r_hist <= '0;
                        end else begin
                            r_seq <= r_seq - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // A lane-0 edge between the two drive samples arms a request;
            // it only takes effect after one more bit-pair has gone by.
            if ((r_state == c_ST_LAT2_POS) && (r_pend == c_PEND_NONE) &&
                (r_hist[0] != r_hist[1])) begin
                r_pend <= c_PEND_ARMED;
            end
            if ((r_state == c_ST_DRV2_NEG) && (r_pend == c_PEND_ARMED)) begin
                r_pend <= c_PEND_FIRE;
            end
        end
    end

    assign DOUT        = r_hold ? {LANES{1'b1}} : r_din;
    assign RESET_CAUSE = r_cause;
    assign RESET_DONE  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mbus_ctrl_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mbus_ctrl_gen2
//  Description : Directed self-checking bench for mbus_ctrl_gen2 with two
//                lanes and an eight bit-pair watchdog. Timing expectations
//                are counted in CLK_IN cycles from the first busy cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mbus_ctrl_gen2;

    logic       CLK_IN = 1'b0;
    logic       RESET;
    logic [7:0] CLK_DIV;
    logic [1:0] DIN;
    logic [1:0] DOUT;
    logic       CLK_OUT;
    logic       BUS_BUSY;
    logic [1:0] RESET_CAUSE;
    logic       RESET_DONE;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int t_rst   = 0;
    int n       = 0;
    int falls   = 0;
    int busy_seen = 0;

    mbus_ctrl_gen2 #(
        .LANES               (2),
        .DIV_W               (8),
        .FILT_DEPTH          (4),
        .START_HALF_CYCLES   (6),
        .RESET_CYCLES        (4),
        .DISABLE_HALF_CYCLES (6),
        .MAX_BITS            (8)
    ) dut (
        .CLK_IN      (CLK_IN),
        .RESET       (RESET),
        .CLK_DIV     (CLK_DIV),
        .DIN         (DIN),
        .DOUT        (DOUT),
        .CLK_OUT     (CLK_OUT),
        .BUS_BUSY    (BUS_BUSY),
        .RESET_CAUSE (RESET_CAUSE),
        .RESET_DONE  (RESET_DONE)
    );

    always #5 CLK_IN = ~CLK_IN;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to the negedge that lies 'target' cycles after the first busy cycle
    task automatic goto(input int target);
        while ((cyc - t0) < target) @(negedge CLK_IN);
    endtask

    // Hold lane 0 low for exactly four clock edges, then confirm entry
    task automatic start_seq(input logic [7:0] div);
        @(negedge CLK_IN);
        CLK_DIV = div;
        DIN     = 2'b10;
        repeat (4) @(negedge CLK_IN);
        DIN = 2'b11;
        check("busy_before_entry", {31'd0, BUS_BUSY}, 32'd0);
        @(negedge CLK_IN);
        check("busy_after_entry", {31'd0, BUS_BUSY}, 32'd1);
        t0 = cyc;
    endtask

    task automatic wait_cause(input int limit);
        int k;
        k = 0;
        while (RESET_CAUSE == 2'b00 && k < limit) begin
            @(negedge CLK_IN);
            k++;
        end
    endtask

    task automatic wait_done(input int limit, output int nfall);
        int  k;
        logic prev;
        k     = 0;
        nfall = 0;
        prev  = CLK_OUT;
        while (RESET_DONE !== 1'b1 && k < limit) begin
            @(negedge CLK_IN);
            k++;
            if (prev && !CLK_OUT) nfall++;
            prev = CLK_OUT;
        end
    endtask

    initial begin
        RESET   = 1'b0;
        CLK_DIV = 8'd3;
        DIN     = 2'b11;
        repeat (3) @(negedge CLK_IN);
        check("rst_clk_out", {31'd0, CLK_OUT}, 32'd1);
        check("rst_dout", {30'd0, DOUT}, 32'd3);
        check("rst_busy", {31'd0, BUS_BUSY}, 32'd0);
        check("rst_cause", {30'd0, RESET_CAUSE}, 32'd0);
        check("rst_done", {31'd0, RESET_DONE}, 32'd0);
        RESET = 1'b1;
        repeat (5) @(negedge CLK_IN);

        // ---- Divider 3: start timing, forwarding, then watchdog reset ----
        start_seq(8'd3);
        n = 0;
        while (CLK_OUT === 1'b1 && n < 200) begin
            @(negedge CLK_IN);
            n++;
        end
        check("start_pos_cycles", n, 32'd24);
        DIN = 2'b01;
        n = 0;
        while (CLK_OUT === 1'b0 && n < 200) begin
            @(negedge CLK_IN);
            n++;
        end
        check("start_neg_cycles", n, 32'd4);
        goto(35);
        check("dout_held_arb_neg", {30'd0, DOUT}, 32'd3);
        goto(36);
        check("dout_released", {30'd0, DOUT}, 32'd1);
        goto(40);
        DIN = 2'b11;
        goto(41);
        check("dout_tracks_din", {30'd0, DOUT}, 32'd3);
        DIN = 2'b01;
        wait_cause(400);
        check("wdog_entry_cycle", cyc - t0, 32'd292);
        check("wdog_cause", {30'd0, RESET_CAUSE}, 32'd2);
        check("wdog_dout_held", {30'd0, DOUT}, 32'd3);
        t_rst = cyc;
        wait_done(100, falls);
        check("wdog_rst_to_done", cyc - t_rst, 32'd56);
        check("wdog_rst_clocks", falls, 32'd4);
        check("wdog_idle_after", {31'd0, BUS_BUSY}, 32'd0);
        check("wdog_cause_held", {30'd0, RESET_CAUSE}, 32'd2);
        @(negedge CLK_IN);
        check("done_single_pulse", {31'd0, RESET_DONE}, 32'd0);

        // ---- Short lane-0 low pulse is rejected ----
        DIN = 2'b11;
        repeat (2) @(negedge CLK_IN);
        DIN = 2'b10;
        repeat (3) @(negedge CLK_IN);
        DIN = 2'b11;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK_IN);
            if (BUS_BUSY !== 1'b0 || CLK_OUT !== 1'b1) busy_seen++;
        end
        check("short_pulse_ignored", busy_seen, 32'd0);

        // ---- Divider 1: interrupt reset, divider edit while busy ----
        start_seq(8'd1);
        check("cause_cleared_on_exit", {30'd0, RESET_CAUSE}, 32'd0);
        CLK_DIV = 8'd5;
        goto(22);
        DIN = 2'b10;
        goto(26);
        check("dout_lane0_low", {30'd0, DOUT}, 32'd2);
        goto(30);
        DIN = 2'b11;
        goto(40);
        DIN = 2'b01;
        wait_cause(200);
        check("irq_entry_cycle", cyc - t0, 32'd50);
        check("irq_cause", {30'd0, RESET_CAUSE}, 32'd1);
        check("irq_dout_held", {30'd0, DOUT}, 32'd3);
        t_rst = cyc;
        wait_done(100, falls);
        check("irq_rst_to_done", cyc - t_rst, 32'd28);
        check("irq_rst_clocks", falls, 32'd4);

        // ---- Divider 0: 1-cycle halves, interrupt coinciding with watchdog ----
        DIN = 2'b11;
        start_seq(8'd0);
        goto(5);
        check("div0_start_pos_last", {31'd0, CLK_OUT}, 32'd1);
        goto(6);
        check("div0_start_neg", {31'd0, CLK_OUT}, 32'd0);
        goto(7);
        check("div0_arb_pos", {31'd0, CLK_OUT}, 32'd1);
        goto(8);
        check("div0_arb_neg", {31'd0, CLK_OUT}, 32'd0);
        goto(59);
        DIN = 2'b10;
        goto(62);
        DIN = 2'b11;
        wait_cause(200);
        check("both_entry_cycle", cyc - t0, 32'd73);
        check("both_cause_wdog", {30'd0, RESET_CAUSE}, 32'd2);
        t_rst = cyc;
        wait_done(100, falls);
        check("both_rst_to_done", cyc - t_rst, 32'd14);
        check("both_rst_clocks", falls, 32'd4);
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK_IN);
            if (BUS_BUSY !== 1'b0) busy_seen++;
        end
        check("single_reset_sequence", busy_seen, 32'd0);

        // ---- Asynchronous reset during DRV2_POS ----
        start_seq(8'd3);
        goto(45);
        DIN = 2'b01;
        goto(53);
        check("pre_reset_dout", {30'd0, DOUT}, 32'd1);
        check("pre_reset_busy", {31'd0, BUS_BUSY}, 32'd1);
        RESET = 1'b0;
        #1;
        check("async_clk_out", {31'd0, CLK_OUT}, 32'd1);
        check("async_dout", {30'd0, DOUT}, 32'd3);
        check("async_busy", {31'd0, BUS_BUSY}, 32'd0);
        @(negedge CLK_IN);
        RESET = 1'b1;
        repeat (4) @(negedge CLK_IN);
        check("post_reset_idle", {31'd0, BUS_BUSY}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
